// File: rtl/noc_arb_pkg.sv
// Shared definitions for the FIFO round-robin arbiter: FSM encoding and
// flit-field helpers.
package noc_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    SEND,
    HOLD
  } arb_state_t;

  // The tail flag lives in the MSB of every flit.
  function automatic int unsigned tail_bit(input int unsigned num_bits);
    return num_bits - 1;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_if.sv
// Bundle between the input FIFOs, the arbiter and the downstream consumer.
// master = arbiter side, slave = FIFO/downstream side.
interface fifo_rr_arbiter_if #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned NUM_BITS  = 8
);
  logic [NUM_PORTS-1:0]          fifo_empty;
  logic [NUM_PORTS*NUM_BITS-1:0] fifo_data;
  logic [NUM_PORTS-1:0]          fifo_rd_en;
  logic [NUM_PORTS-1:0]          grant;
  logic [NUM_BITS-1:0]           out_data;
  logic                          out_valid;
  logic                          out_ready;
  logic                          busy;

  modport master (
    input  fifo_empty, fifo_data, out_ready,
    output fifo_rd_en, grant, out_data, out_valid, busy
  );

  modport slave (
    output fifo_empty, fifo_data, out_ready,
    input  fifo_rd_en, grant, out_data, out_valid, busy
  );
endinterface

// File: rtl/fifo_rr_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last_ptr, wrapping
// modulo NUM_PORTS.
module rr_picker
  import noc_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned PTR_W     = ptr_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     last_ptr,
  output logic [NUM_PORTS-1:0] pick,
  output logic                 valid
);

  always_comb begin
    int unsigned idx;
    pick  = '0;
    valid = 1'b0;
    idx   = 0;
    // Offsets 1..NUM_PORTS so that last_ptr itself is examined last.
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      idx = 32'(last_ptr) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!valid && req[idx[PTR_W-1:0]]) begin
        pick[idx[PTR_W-1:0]] = 1'b1;
        valid                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Packet-level round-robin arbiter draining NUM_PORTS input FIFOs onto one
// valid/ready output channel; a grant is held until a tail flit is sent.
module fifo_rr_arbiter
  import noc_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned NUM_BITS  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  fifo_rr_arbiter_if.master bus
);

  localparam int unsigned PTR_W = ptr_width(NUM_PORTS);
  localparam int unsigned TAIL  = tail_bit(NUM_BITS);

  arb_state_t           state;
  logic [NUM_PORTS-1:0] grant_q;
  logic [NUM_PORTS-1:0] rd_en_q;
  logic [NUM_BITS-1:0]  out_data_q;
  logic                 out_valid_q;
  logic [PTR_W-1:0]     last_ptr;

  logic [NUM_PORTS-1:0] pick;
  logic                 pick_valid;
  logic [NUM_BITS-1:0]  granted_data;
  logic [PTR_W-1:0]     grant_idx;
  logic                 granted_ready;

  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_picker (
    .req      (~bus.fifo_empty),
    .last_ptr (last_ptr),
    .pick     (pick),
    .valid    (pick_valid)
  );

  // One-hot grant mux and encoder; grant is one-hot or zero by construction.
  always_comb begin
    granted_data = '0;
    grant_idx    = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (grant_q[p]) begin
        granted_data = granted_data | bus.fifo_data[p*NUM_BITS +: NUM_BITS];
        grant_idx    = PTR_W'(p);
      end
    end
    granted_ready = |(grant_q & ~bus.fifo_empty);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state       <= IDLE;
      grant_q     <= '0;
      rd_en_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      last_ptr    <= PTR_W'(NUM_PORTS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_q <= pick;
            rd_en_q <= pick;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          rd_en_q <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          out_data_q  <= granted_data;
          out_valid_q <= 1'b1;
          state       <= SEND;
        end
        SEND: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (out_data_q[TAIL]) begin
              last_ptr <= grant_idx;
              grant_q  <= '0;
              state    <= IDLE;
            end else if (granted_ready) begin
              rd_en_q <= grant_q;
              state   <= ISSUE;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (granted_ready) begin
            rd_en_q <= grant_q;
            state   <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.fifo_rd_en = rd_en_q;
  assign bus.grant      = grant_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter with a behavioural model of the input
// FIFOs (one-cycle read latency) and a handshake log.
module tb_fifo_rr_arbiter;
  import noc_arb_pkg::*;

  localparam int unsigned NP = 4;
  localparam int unsigned NB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fifo_rr_arbiter_if #(.NUM_PORTS(NP), .NUM_BITS(NB)) bus ();

  fifo_rr_arbiter #(.NUM_PORTS(NP), .NUM_BITS(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [NP-1:0] push_en = '0;
  logic [NB-1:0] push_data [NP];
  logic [NB-1:0] q [NP][$];

  typedef struct {
    logic [NP-1:0] g;
    logic [NB-1:0] d;
    int unsigned   cyc;
  } hs_t;
  hs_t log_q[$];

  int unsigned cyc       = 0;
  int unsigned rd_pulses = 0;
  int unsigned rule_viol = 0;
  int unsigned n_checks  = 0;
  int unsigned n_pass    = 0;

  // Input FIFO model: pop on rd_en, data visible the following cycle.
  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int p = 0; p < NP; p++) q[p] = {};
      bus.fifo_empty <= '1;
      bus.fifo_data  <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (bus.fifo_rd_en[p] && q[p].size() > 0)
          bus.fifo_data[p*NB +: NB] <= q[p].pop_front();
        if (push_en[p]) q[p].push_back(push_data[p]);
        bus.fifo_empty[p] <= (q[p].size() == 0);
      end
    end
  end

  always @(posedge clk) begin
    hs_t e;
    cyc++;
    if (bus.out_valid && bus.out_ready) begin
      e.g   = bus.grant;
      e.d   = bus.out_data;
      e.cyc = cyc;
      log_q.push_back(e);
    end
    if (|bus.fifo_rd_en) rd_pulses++;
    if ((|(bus.fifo_rd_en & bus.fifo_empty)) || ((|bus.fifo_rd_en) && bus.out_valid) ||
        ($countones(bus.fifo_rd_en) > 1))
      rule_viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int unsigned n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push1(input int unsigned p, input logic [NB-1:0] d);
    push_en[p]   = 1'b1;
    push_data[p] = d;
    tick();
    push_en[p]   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    tick(2);
    rst_n = 1'b0;
    tick();
  endtask

  task automatic wait_log(input int unsigned target, input string tag);
    int unsigned k = 0;
    while (log_q.size() < target && k < 40) begin
      tick();
      k++;
    end
    check(tag, 32'(log_q.size() >= target), 1);
  endtask

  task automatic expect_hs(input string tag, input int unsigned i,
                           input logic [NP-1:0] g, input logic [NB-1:0] d);
    hs_t e;
    e = (i < log_q.size()) ? log_q[i] : '{g: '0, d: '0, cyc: 0};
    check({tag, "_grant"}, 32'(e.g), 32'(g));
    check({tag, "_data"},  32'(e.d), 32'(d));
  endtask

  initial begin
    int unsigned base;
    int unsigned r0;
    int unsigned k;
    for (int p = 0; p < NP; p++) push_data[p] = '0;
    bus.out_ready = 1'b1;

    // Reset values
    tick(3);
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_rd_en", 32'(bus.fifo_rd_en), 0);
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_data",  32'(bus.out_data), 0);
    check("rst_busy",  32'(bus.busy), 0);
    check("rst_last_ptr", 32'(dut.last_ptr), 3);
    rst_n = 1'b0;
    tick();

    // Single tail flit on port 0, cycle by cycle
    push1(0, 8'h85);
    check("t1_idle_grant", 32'(bus.grant), 0);
    tick();
    check("t1_issue_rd_en", 32'(bus.fifo_rd_en), 'h1);
    check("t1_issue_grant", 32'(bus.grant), 'h1);
    check("t1_issue_busy",  32'(bus.busy), 1);
    check("t1_issue_valid", 32'(bus.out_valid), 0);
    tick();
    check("t1_wait_rd_en", 32'(bus.fifo_rd_en), 0);
    check("t1_wait_valid", 32'(bus.out_valid), 0);
    tick();
    check("t1_send_data",  32'(bus.out_data), 'h85);
    check("t1_send_valid", 32'(bus.out_valid), 1);
    tick();
    check("t1_done_grant", 32'(bus.grant), 0);
    check("t1_done_valid", 32'(bus.out_valid), 0);
    check("t1_done_busy",  32'(bus.busy), 0);

    // Ports 0 and 2, then a fresh tie goes to port 0
    do_reset();
    base = log_q.size();
    push_en[0] = 1'b1; push_data[0] = 8'h81;
    push_en[2] = 1'b1; push_data[2] = 8'h82;
    tick();
    push_en = '0;
    wait_log(base + 2, "t2_first_pair");
    push_en[0] = 1'b1; push_data[0] = 8'h83;
    push_en[2] = 1'b1; push_data[2] = 8'h84;
    tick();
    push_en = '0;
    wait_log(base + 4, "t2_second_pair");
    expect_hs("t2_0", base + 0, 4'b0001, 8'h81);
    expect_hs("t2_1", base + 1, 4'b0100, 8'h82);
    expect_hs("t2_2", base + 2, 4'b0001, 8'h83);
    expect_hs("t2_3", base + 3, 4'b0100, 8'h84);

    // Three-flit packet on port 1 locks out port 3
    do_reset();
    base = log_q.size();
    push_en[1] = 1'b1; push_data[1] = 8'h11;
    push_en[3] = 1'b1; push_data[3] = 8'hBF;
    tick();
    push_en[3] = 1'b0; push_data[1] = 8'h12;
    tick();
    push_data[1] = 8'h93;
    tick();
    push_en = '0;
    wait_log(base + 4, "t3_all");
    expect_hs("t3_0", base + 0, 4'b0010, 8'h11);
    expect_hs("t3_1", base + 1, 4'b0010, 8'h12);
    expect_hs("t3_2", base + 2, 4'b0010, 8'h93);
    expect_hs("t3_3", base + 3, 4'b1000, 8'hBF);
    if (log_q.size() >= base + 3) begin
      check("t3_gap_01", log_q[base+1].cyc - log_q[base].cyc, 3);
      check("t3_gap_12", log_q[base+2].cyc - log_q[base+1].cyc, 3);
    end

    // Port 1 starves mid-packet: HOLD keeps the grant, port 0 ignored
    base = log_q.size();
    push1(1, 8'h11);
    wait_log(base + 1, "t4_head");
    check("t4_state_hold", 32'(dut.state), 32'(HOLD));
    push1(0, 8'h80);
    r0 = rd_pulses;
    tick(4);
    check("t4_hold_state", 32'(dut.state), 32'(HOLD));
    check("t4_hold_grant", 32'(bus.grant), 'b0010);
    check("t4_hold_busy",  32'(bus.busy), 1);
    check("t4_hold_rd",    rd_pulses - r0, 0);
    push1(1, 8'h92);
    wait_log(base + 3, "t4_all");
    expect_hs("t4_0", base + 0, 4'b0010, 8'h11);
    expect_hs("t4_1", base + 1, 4'b0010, 8'h92);
    expect_hs("t4_2", base + 2, 4'b0001, 8'h80);

    // Backpressure in SEND
    bus.out_ready = 1'b0;
    base = log_q.size();
    push1(2, 8'h26);
    push1(2, 8'hA7);
    k = 0;
    while (!bus.out_valid && k < 20) begin
      tick();
      k++;
    end
    check("t5_valid_seen", 32'(bus.out_valid), 1);
    r0 = rd_pulses;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_stall_data",  32'(bus.out_data), 'h26);
      check("t5_stall_valid", 32'(bus.out_valid), 1);
    end
    check("t5_stall_rd", rd_pulses - r0, 0);
    bus.out_ready = 1'b1;
    wait_log(base + 2, "t5_all");
    expect_hs("t5_0", base + 0, 4'b0100, 8'h26);
    expect_hs("t5_1", base + 1, 4'b0100, 8'hA7);

    // Asynchronous reset during WAIT
    base = log_q.size();
    push1(3, 8'hB3);
    k = 0;
    while (dut.state != WAIT && k < 20) begin
      tick();
      k++;
    end
    check("t6_in_wait", 32'(dut.state), 32'(WAIT));
    rst_n = 1'b1;
    #1;
    check("t6_grant", 32'(bus.grant), 0);
    check("t6_rd_en", 32'(bus.fifo_rd_en), 0);
    check("t6_valid", 32'(bus.out_valid), 0);
    check("t6_data",  32'(bus.out_data), 0);
    check("t6_busy",  32'(bus.busy), 0);
    tick();
    rst_n = 1'b0;
    tick();
    push_en[0] = 1'b1; push_data[0] = 8'h84;
    push_en[3] = 1'b1; push_data[3] = 8'hB4;
    tick();
    push_en = '0;
    wait_log(base + 2, "t6_all");
    expect_hs("t6_0", base + 0, 4'b0001, 8'h84);
    expect_hs("t6_1", base + 1, 4'b1000, 8'hB4);

    check("rd_en_rules", rule_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_rr_arbiter.md
FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of requesting input FIFOs.
REQ-002 Parameter NUM_BITS, default 8: flit width; bit NUM_BITS-1 is the tail flag.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-high.
REQ-005 fifo_empty  input  NUM_PORTS  empty flag of each input FIFO.
REQ-006 fifo_data  input  NUM_PORTS*NUM_BITS  registered FIFO outputs, port p at bits [p*NUM_BITS +: NUM_BITS].
REQ-007 fifo_rd_en  output  NUM_PORTS  one-hot read strobe to the input FIFOs.
REQ-008 grant  output  NUM_PORTS  one-hot owner of the output channel, zero when idle.
REQ-009 out_data  output  NUM_BITS  flit presented downstream.
REQ-010 out_valid  output  1  out_data holds a valid flit.
REQ-011 out_ready  input  1  downstream accepts flit when out_valid and out_ready are both high.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM states: IDLE, ISSUE, WAIT, SEND, HOLD.
REQ-014 IDLE: if any fifo_empty bit is 0, pick the first non-empty port searching from last_ptr+1 upward, modulo NUM_PORTS; load grant; go to ISSUE. Otherwise stay.
REQ-015 ISSUE: fifo_rd_en[g]=1 for exactly this one cycle; all other fifo_rd_en bits 0; go to WAIT.
REQ-016 WAIT: at the end of this cycle, capture fifo_data slice g into out_data and set out_valid; go to SEND. FIFO read latency is one cycle.
REQ-017 SEND: hold out_data and out_valid stable until out_ready=1.
REQ-018 On the SEND handshake with tail=1: clear out_valid; set last_ptr to g; clear grant; go to IDLE.
REQ-019 On the SEND handshake with tail=0: clear out_valid. If fifo_empty[g]=0, go to ISSUE; otherwise go to HOLD. The grant stays locked to g.
REQ-020 HOLD: keep the grant; go to ISSUE when fifo_empty[g]=0. Requests from other ports are ignored until a tail flit is sent.
REQ-021 fifo_rd_en is never asserted for a port whose fifo_empty bit is 1, and is never asserted while out_valid=1.
REQ-022 Minimum spacing is 3 cycles per flit (ISSUE, WAIT, SEND with out_ready=1). IDLE adds one arbitration cycle per packet.
REQ-023 Round-robin: after port p sends a tail, port p has the lowest priority in the next arbitration. No port waits more than NUM_PORTS-1 packets.
REQ-024 last_ptr width is clog2(NUM_PORTS). Its increment wraps from NUM_PORTS-1 to 0.

Reset
REQ-025 While rst_n=1: state=IDLE, grant=0, fifo_rd_en=0, out_data=0, out_valid=0, busy=0, last_ptr=NUM_PORTS-1, so port 0 wins the first arbitration.
REQ-026 Reset asserted mid-operation returns all outputs to reset values immediately, regardless of clock. Any flit in flight is discarded; the FIFOs share the same rst_n.

Structure
REQ-027 Shared package noc_arb_pkg holds the FSM state encoding and the TAIL_BIT index function.
REQ-028 Round-robin selection is the sub-module rr_picker: combinational, with inputs request vector and last_ptr, and outputs a one-hot pick and a valid flag.

Verification
REQ-029 Reset, then port 0 FIFO holds the single flit 0x85 (tail) -> rd_en[0] pulses one cycle; out_data=0x85 and out_valid=1 two cycles after ISSUE; grant returns to 0 after the handshake.
REQ-030 Ports 0 and 2 each hold one tail flit, 0x81 and 0x82, out_ready=1 -> port 0 is served first, then port 2; after that, a new flit on port 0 beats a simultaneous new flit on port 2.
REQ-031 Port 1 sends the packet 0x11, 0x12, 0x93 while port 3 is requesting -> all three flits go out contiguously, with grant=0010 throughout; port 3 is served only after 0x93.
REQ-032 Port 1 sends 0x11, then its FIFO is empty for 5 cycles, then 0x92 arrives -> state is HOLD, no rd_en pulses, and the grant is held; 0x92 is then sent.
REQ-033 out_ready is held 0 for 4 cycles while in SEND -> out_data is stable, out_valid=1, and there is no further rd_en.
REQ-034 rst_n is pulsed during WAIT -> all outputs go to 0 within the same cycle; afterwards, arbitration restarts from port 0.
